l2_cache_control: RTL and testbench

Control FSM for the 2-way set-associative L2 cache. It sequences the L2 tag, valid, dirty, LRU and data arrays, all of which have one-cycle registered reads, for requests arriving from the L1 side. It services hits and runs dirty-victim writeback and line fill against physical memory. It also keeps hit/miss performance counters. It sits between the L1 arbiter (upstream) and the cacheline adapter (downstream) and drives only control; addresses and data stay in the L2 datapath.

---
 rtl/l2_cache_control.sv | 133 +++++++++++++
 tb/tb_l2_cache_control.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_control.sv
// Control FSM for the 2-way set-associative L2: hit service, dirty writeback, line fill
// and saturating hit/miss counters. Array-control outputs are decoded from state and inputs.
module l2_cache_control #(
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           hit,
  input  logic [1:0]           dirty,
  input  logic                 lru,
  input  logic                 pmem_resp,
  output logic                 read_arrays,
  output logic [1:0]           load_tag,
  output logic [1:0]           load_valid,
  output logic [1:0]           load_dirty,
  output logic [1:0]           load_data,
  output logic                 dirty_in,
  output logic                 load_lru,
  output logic                 lru_in,
  output logic                 data_in_sel,
  output logic                 pmem_addr_sel,
  output logic                 way_sel,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count
);

  // state     | meaning
  // IDLE      | waiting for an upstream request; issues the array read
  // COMPARE   | array outputs valid; hit service or miss dispatch
  // WRITEBACK | dirty victim line written to physical memory
  // FILL      | line read from physical memory into the victim way
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  state_t state;
  logic   victim;
  logic   req;
  logic   any_hit;
  logic   hit_way;

  assign req     = mem_read | mem_write;
  assign any_hit = |hit;
  // way0 wins on the illegal double-hit
  assign hit_way = hit[1] & ~hit[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      victim     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) state <= COMPARE;
        end
        COMPARE: begin
          if (any_hit) begin
            state <= IDLE;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end else begin
            victim <= lru;
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            state <= dirty[lru] ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) state <= FILL;
        end
        FILL: begin
          if (pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    read_arrays   = 1'b0;
    load_tag      = 2'b00;
    load_valid    = 2'b00;
    load_dirty    = 2'b00;
    load_data     = 2'b00;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    data_in_sel   = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    // reset masks everything so no array is written and pmem requests drop at once
    if (!rst) begin
      case (state)
        IDLE: read_arrays = req;
        COMPARE: begin
          if (any_hit) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            load_lru = 1'b1;
            lru_in   = ~hit_way;
            if (mem_write) begin
              load_data[hit_way]  = 1'b1;
              load_dirty[hit_way] = 1'b1;
              dirty_in            = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
        end
        FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_data[victim]  = 1'b1;
            load_tag[victim]   = 1'b1;
            load_valid[victim] = 1'b1;
            load_dirty[victim] = 1'b1;
            data_in_sel        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_control.sv
// Scoreboard bench for l2_cache_control: directed requests push expected responses,
// a monitor pops and compares on mem_resp and fill loads; a responder models pmem.
module tb_l2_cache_control;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, mem_read, mem_write, lru, pmem_resp;
  logic [1:0]    hit, dirty;
  logic          read_arrays, dirty_in, load_lru, lru_in, data_in_sel;
  logic          pmem_addr_sel, way_sel, mem_resp, pmem_read, pmem_write;
  logic [1:0]    load_tag, load_valid, load_dirty, load_data;
  logic [CW-1:0] hit_count, miss_count;

  l2_cache_control #(.cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .dirty(dirty), .lru(lru), .pmem_resp(pmem_resp),
    .read_arrays(read_arrays), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .load_data(load_data), .dirty_in(dirty_in),
    .load_lru(load_lru), .lru_in(lru_in), .data_in_sel(data_in_sel),
    .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit wr;
    bit way;
    int cyc;
  } resp_t;

  resp_t resp_q[$];
  bit    fill_q[$];
  int    wb_delay = 1;
  int    fill_delay = 1;
  bit    fill_way = 1'b0;
  int    exp_hits = 0;
  int    exp_misses = 0;

  // physical memory: completes after a programmed number of request cycles;
  // on a fill it also makes the re-lookup hit in the filled way
  initial begin
    int  pcnt;
    bit  was;
    pmem_resp = 1'b0;
    pcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      was = pmem_resp;
      pmem_resp = 1'b0;
      if (was) pcnt = 0;
      if (!rst && (pmem_read || pmem_write)) begin
        pcnt++;
        if (pcnt == (pmem_write ? wb_delay : fill_delay)) begin
          pmem_resp = 1'b1;
          if (pmem_read) hit = 2'b01 << fill_way;
        end
      end else begin
        pcnt = 0;
      end
    end
  end

  logic prev_wb_resp = 1'b0;
  logic prev_fill_resp = 1'b0;
  always @(posedge clk) begin
    prev_wb_resp   <= pmem_resp && pmem_write && !rst;
    prev_fill_resp <= pmem_resp && pmem_read && !rst;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pmem_read || pmem_write) begin
        check("pmem_exclusive", int'(pmem_read & pmem_write), 0);
        check("pmem_addr_sel", int'(pmem_addr_sel), int'(pmem_write));
      end
      if (prev_wb_resp) begin
        check("wb_drop_write", int'(pmem_write), 0);
        check("wb_then_read", int'(pmem_read), 1);
      end
      if (prev_fill_resp) begin
        check("fill_drop_read", int'(pmem_read), 0);
        check("fill_no_write", int'(pmem_write), 0);
      end
      if (mem_resp) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_cycle", cyc, r.cyc);
          check("way_sel", int'(way_sel), int'(r.way));
          check("load_lru", int'(load_lru), 1);
          check("lru_in", int'(lru_in), int'(!r.way));
          check("hit_load_data", int'(load_data), r.wr ? int'(2'b01 << r.way) : 0);
          check("hit_load_dirty", int'(load_dirty), r.wr ? int'(2'b01 << r.way) : 0);
          if (r.wr) begin
            check("hit_dirty_in", int'(dirty_in), 1);
            check("hit_data_in_sel", int'(data_in_sel), 0);
          end
        end
      end
      if (load_tag != 2'b00) begin
        if (fill_q.size() == 0) begin
          check("unexpected_fill", 1, 0);
        end else begin
          bit v;
          int m;
          v = fill_q.pop_front();
          m = int'(2'b01 << v);
          check("fill_load_tag", int'(load_tag), m);
          check("fill_load_valid", int'(load_valid), m);
          check("fill_load_data", int'(load_data), m);
          check("fill_load_dirty", int'(load_dirty), m);
          check("fill_dirty_in", int'(dirty_in), 0);
          check("fill_data_in_sel", int'(data_in_sel), 1);
          check("fill_no_lru", int'(load_lru), 0);
        end
      end
    end
  end

  function automatic int sat_inc(input int x);
    return (x < (1 << CW) - 1) ? x + 1 : x;
  endfunction

  // issue one request at posedge+1 and hold it until mem_resp, then drop it
  task automatic req(input bit wr, input bit both, input logic [1:0] hv,
                     input logic [1:0] dv, input bit lv, input int dw, input int df);
    resp_t r;
    bit    got;
    hit = hv; dirty = dv; lru = lv;
    wb_delay = dw; fill_delay = df;
    mem_write = wr;
    mem_read  = !wr || both;
    r.wr = wr;
    if (hv != 2'b00) begin
      r.way = hv[0] ? 1'b0 : 1'b1;
      r.cyc = cyc + 1;
      exp_hits = sat_inc(exp_hits);
    end else begin
      fill_way = lv;
      fill_q.push_back(lv);
      r.way = lv;
      r.cyc = dv[lv] ? cyc + 3 + dw + df : cyc + 3 + df;
      exp_misses = sat_inc(exp_misses);
      exp_hits = sat_inc(exp_hits);
    end
    resp_q.push_back(r);
    @(negedge clk);
    check("read_arrays", int'(read_arrays), 1);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_resp) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("resp_timeout", 0, 1);
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
  endtask

  task automatic check_counts();
    check("hit_count", int'(hit_count), exp_hits);
    check("miss_count", int'(miss_count), exp_misses);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pmem_read"}, int'(pmem_read), 0);
    check({tag, "_pmem_write"}, int'(pmem_write), 0);
    check({tag, "_loads"}, int'({load_tag, load_valid, load_dirty, load_data, load_lru}), 0);
    check({tag, "_mem_resp"}, int'(mem_resp), 0);
    check({tag, "_read_arrays"}, int'(read_arrays), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    hit = 2'b00; dirty = 2'b00; lru = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    check_counts();
    @(posedge clk); #1;

    req(0, 0, 2'b10, 2'b00, 1'b0, 1, 1);   // read hit way1
    check_counts();
    req(1, 0, 2'b01, 2'b00, 1'b1, 1, 1);   // write hit way0
    req(0, 0, 2'b00, 2'b00, 1'b1, 1, 5);   // clean read miss, fill way1
    check_counts();
    req(1, 0, 2'b00, 2'b01, 1'b0, 3, 2);   // dirty write miss, writeback then fill way0
    req(1, 1, 2'b11, 2'b00, 1'b1, 1, 1);   // read+write, double hit: write to way0
    req(0, 0, 2'b10, 2'b11, 1'b0, 1, 1);   // read hit, dirty bits irrelevant
    check_counts();

    // reset while FILL is outstanding
    hit = 2'b00; dirty = 2'b00; lru = 1'b0; fill_delay = 50; fill_way = 1'b0;
    mem_read = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_read) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("fill_start_timeout", 0, 1);
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check("rst_cycle_pmem_read", int'(pmem_read), 0);
    check("rst_cycle_loads", int'({load_tag, load_valid, load_dirty, load_data, load_lru}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    check_quiet("post_rst");
    check_counts();
    @(posedge clk); #1;

    // saturation: 17 hits on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      req(0, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1'b0, 1, 1);
    end
    check_counts();
    check("resp_q_drained", resp_q.size(), 0);
    check("fill_q_drained", fill_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
